// File: rtl/reg_wb_arbiter_pkg.sv
// Shared constants and types for the register-file writeback arbiter.
// Requester indices, default widths, zero-register address and write-enable encoding.
package reg_wb_arbiter_pkg;

    localparam int NUM_REQ = 3;
    localparam int REQ_ALU = 0;
    localparam int REQ_MEM = 1;
    localparam int REQ_RA  = 2;

    localparam int DATA_W_DEF = 16;
    localparam int ADDR_W_DEF = 4;

    localparam int unsigned ZERO_REG_ADDR = 0;

    typedef enum logic {
        WB_IDLE  = 1'b0,
        WB_WRITE = 1'b1
    } wb_write_e;

    typedef logic [1:0] req_idx_t;

    // Round-robin successor: ALU -> MEM -> RA -> ALU.
    function automatic req_idx_t next_idx(input req_idx_t idx);
        return (idx == req_idx_t'(NUM_REQ - 1)) ? req_idx_t'(0) : idx + 2'd1;
    endfunction

endpackage

// File: rtl/reg_wb_arbiter_if.sv
// Bus between the writeback requesters/decode stage and the arbiter.
// master = requesters and decode lookup; slave = the arbiter.
interface reg_wb_arbiter_if
    import reg_wb_arbiter_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
);

    logic              alu_valid;
    logic [ADDR_W-1:0] alu_addr;
    logic [DATA_W-1:0] alu_value;
    logic              alu_ready;

    logic              mem_valid;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_value;
    logic              mem_ready;

    logic              ra_valid;
    logic [ADDR_W-1:0] ra_addr;
    logic [DATA_W-1:0] ra_value;
    logic              ra_ready;

    logic              wb_writable;
    logic [ADDR_W-1:0] wb_addr;
    logic [DATA_W-1:0] wb_value;

    logic [ADDR_W-1:0] lookup_addr1;
    logic [ADDR_W-1:0] lookup_addr2;
    logic              pend_hit1;
    logic              pend_hit2;
    logic [DATA_W-1:0] pend_value1;
    logic [DATA_W-1:0] pend_value2;

    modport master (
        output alu_valid, alu_addr, alu_value,
        output mem_valid, mem_addr, mem_value,
        output ra_valid, ra_addr, ra_value,
        output lookup_addr1, lookup_addr2,
        input  alu_ready, mem_ready, ra_ready,
        input  wb_writable, wb_addr, wb_value,
        input  pend_hit1, pend_hit2, pend_value1, pend_value2
    );

    modport slave (
        input  alu_valid, alu_addr, alu_value,
        input  mem_valid, mem_addr, mem_value,
        input  ra_valid, ra_addr, ra_value,
        input  lookup_addr1, lookup_addr2,
        output alu_ready, mem_ready, ra_ready,
        output wb_writable, wb_addr, wb_value,
        output pend_hit1, pend_hit2, pend_value1, pend_value2
    );

endinterface

// File: rtl/reg_wb_arbiter_wb_slot.sv
// One-entry writeback holding buffer with valid/ready handshake.
// A zero-register transfer is accepted but stores nothing.
module reg_wb_arbiter_wb_slot
    import reg_wb_arbiter_pkg::*;
#(
    parameter int          DATA_W   = DATA_W_DEF,
    parameter int          ADDR_W   = ADDR_W_DEF,
    parameter int unsigned ZERO_REG = ZERO_REG_ADDR
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid_i,
    input  logic [ADDR_W-1:0] req_addr_i,
    input  logic [DATA_W-1:0] req_value_i,
    input  logic              grant_i,
    output logic              ready_o,
    output logic              load_o,
    output logic              valid_o,
    output logic [ADDR_W-1:0] addr_o,
    output logic [DATA_W-1:0] value_o
);

    localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(ZERO_REG);

    logic              valid_q, valid_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] value_q, value_d;

    // A granted entry leaves at this edge, so its slot can refill in the same cycle.
    assign ready_o = !valid_q || grant_i;
    assign load_o  = req_valid_i && ready_o && (req_addr_i != ZERO_ADDR);

    // NOTE: every always_comb output gets a default first, so no path leaves it unassigned (no latch).
    always_comb begin
        valid_d = valid_q;
        addr_d  = addr_q;
        value_d = value_q;
        if (load_o) begin
            valid_d = 1'b1;
            addr_d  = req_addr_i;
            value_d = req_value_i;
        end else if (grant_i) begin
            valid_d = 1'b0;
        end
    end

    // NOTE: state is updated with non-blocking assignments only; blocking here would race other flops.
    // NOTE: addr/value are reset too -- cheap at one entry and keeps the lookup muxes free of X.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= 1'b0;
            addr_q  <= '0;
            value_q <= '0;
        end else begin
            valid_q <= valid_d;
            addr_q  <= addr_d;
            value_q <= value_d;
        end
    end

    assign valid_o = valid_q;
    assign addr_o  = addr_q;
    assign value_o = value_q;

endmodule

// File: rtl/reg_wb_arbiter.sv
// Shares the register-file write port between ALU, memory-load and link writebacks.
// Oldest-first per register, round-robin across requesters, with pending-value forwarding.
module reg_wb_arbiter
    import reg_wb_arbiter_pkg::*;
#(
    parameter int          DATA_W   = DATA_W_DEF,
    parameter int          ADDR_W   = ADDR_W_DEF,
    parameter int unsigned ZERO_REG = ZERO_REG_ADDR
) (
    input  logic             clk,
    input  logic             rst,
    reg_wb_arbiter_if.slave  bus
);

    localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(ZERO_REG);

    logic [NUM_REQ-1:0] req_valid;
    logic [ADDR_W-1:0]  req_addr   [NUM_REQ];
    logic [DATA_W-1:0]  req_value  [NUM_REQ];
    logic [NUM_REQ-1:0] slot_ready;
    logic [NUM_REQ-1:0] slot_load;
    logic [NUM_REQ-1:0] slot_valid;
    logic [ADDR_W-1:0]  slot_addr  [NUM_REQ];
    logic [DATA_W-1:0]  slot_value [NUM_REQ];

    logic [NUM_REQ-1:0] eligible;
    logic [NUM_REQ-1:0] grant;
    logic [NUM_REQ-1:0] keep;
    logic               grant_found;
    req_idx_t           grant_idx;
    req_idx_t           scan_idx;
    req_idx_t           rr_ptr_q, rr_ptr_d;

    // older_q[i][j] set means entry i was loaded before entry j.
    logic [NUM_REQ-1:0] older_q [NUM_REQ];
    logic [NUM_REQ-1:0] older_d [NUM_REQ];

    wb_write_e          wb_en;
    logic [ADDR_W-1:0]  lookup_addr [2];
    logic [NUM_REQ-1:0] lk_match    [2];
    logic [1:0]         pend_hit;
    logic [DATA_W-1:0]  pend_value  [2];

    assign req_valid = {bus.ra_valid, bus.mem_valid, bus.alu_valid};
    assign req_addr[REQ_ALU]  = bus.alu_addr;
    assign req_addr[REQ_MEM]  = bus.mem_addr;
    assign req_addr[REQ_RA]   = bus.ra_addr;
    assign req_value[REQ_ALU] = bus.alu_value;
    assign req_value[REQ_MEM] = bus.mem_value;
    assign req_value[REQ_RA]  = bus.ra_value;

    assign bus.alu_ready = slot_ready[REQ_ALU];
    assign bus.mem_ready = slot_ready[REQ_MEM];
    assign bus.ra_ready  = slot_ready[REQ_RA];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_slot
        reg_wb_arbiter_wb_slot #(
            .DATA_W   (DATA_W),
            .ADDR_W   (ADDR_W),
            .ZERO_REG (ZERO_REG)
        ) u_slot (
            .clk         (clk),
            .rst         (rst),
            .req_valid_i (req_valid[g]),
            .req_addr_i  (req_addr[g]),
            .req_value_i (req_value[g]),
            .grant_i     (grant[g]),
            .ready_o     (slot_ready[g]),
            .load_o      (slot_load[g]),
            .valid_o     (slot_valid[g]),
            .addr_o      (slot_addr[g]),
            .value_o     (slot_value[g])
        );
    end

    // An entry waits while an older entry targets the same register.
    always_comb begin
        eligible = slot_valid;
        for (int i = 0; i < NUM_REQ; i++) begin
            for (int j = 0; j < NUM_REQ; j++) begin
                if ((j != i) && slot_valid[j] && (slot_addr[j] == slot_addr[i]) && older_q[j][i]) begin
                    eligible[i] = 1'b0;
                end
            end
        end
    end

    always_comb begin
        grant       = '0;
        grant_found = 1'b0;
        grant_idx   = rr_ptr_q;
        scan_idx    = rr_ptr_q;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!grant_found && eligible[scan_idx]) begin
                grant_found = 1'b1;
                grant_idx   = scan_idx;
            end
            scan_idx = next_idx(scan_idx);
        end
        if (grant_found) begin
            grant[grant_idx] = 1'b1;
        end
        rr_ptr_d = grant_found ? next_idx(grant_idx) : rr_ptr_q;
    end

    // A new entry is younger than everything that stays; same-edge loads order by index.
    assign keep = slot_valid & ~grant & ~slot_load;

    always_comb begin
        older_d = older_q;
        for (int i = 0; i < NUM_REQ; i++) begin
            for (int j = 0; j < NUM_REQ; j++) begin
                if (i == j) begin
                    older_d[i][j] = 1'b0;
                end else if (slot_load[j]) begin
                    older_d[i][j] = keep[i] || (slot_load[i] && (i < j));
                end else if (slot_load[i]) begin
                    older_d[i][j] = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            older_q  <= '{default: '0};
            rr_ptr_q <= req_idx_t'(REQ_ALU);
        end else begin
            older_q  <= older_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    always_comb begin
        wb_en        = WB_IDLE;
        bus.wb_addr  = '0;
        bus.wb_value = '0;
        if (grant_found) begin
            wb_en        = WB_WRITE;
            bus.wb_addr  = slot_addr[grant_idx];
            bus.wb_value = slot_value[grant_idx];
        end
    end

    assign bus.wb_writable = wb_en;

    // Granted entries still forward: the register file is written only at the coming edge.
    assign lookup_addr[0] = bus.lookup_addr1;
    assign lookup_addr[1] = bus.lookup_addr2;

    always_comb begin
        for (int p = 0; p < 2; p++) begin
            pend_hit[p]   = 1'b0;
            pend_value[p] = '0;
            for (int i = 0; i < NUM_REQ; i++) begin
                lk_match[p][i] = slot_valid[i] && (slot_addr[i] == lookup_addr[p]) &&
                                 (lookup_addr[p] != ZERO_ADDR);
            end
            for (int i = 0; i < NUM_REQ; i++) begin
                if (lk_match[p][i]) begin
                    pend_hit[p] = 1'b1;
                    if ((lk_match[p] & older_q[i]) == '0) begin
                        pend_value[p] = slot_value[i];
                    end
                end
            end
        end
    end

    assign bus.pend_hit1   = pend_hit[0];
    assign bus.pend_hit2   = pend_hit[1];
    assign bus.pend_value1 = pend_value[0];
    assign bus.pend_value2 = pend_value[1];

endmodule

// File: tb/tb_reg_wb_arbiter.sv
// Self-checking bench for reg_wb_arbiter: directed vector table, hand sequences,
// and randomized traffic against a timestamp-based reference model.
module tb_reg_wb_arbiter;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    reg_wb_arbiter_if bus ();

    reg_wb_arbiter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    typedef struct {
        logic [2:0]  v;          // {ra, mem, alu}
        logic [3:0]  a0, a1, a2;
        logic [15:0] d0, d1, d2;
        logic [3:0]  lk1, lk2;
        logic        ewr;
        logic [3:0]  eaddr;
        logic [15:0] eval;
        logic [2:0]  erdy;       // {ra, mem, alu}
        logic        ehit1, ehit2;
        logic [15:0] epv1, epv2;
    } vec_t;

    vec_t tbl [15];

    // Reference model: each slot carries a global load stamp; smaller stamp = older.
    bit          m_v  [3];
    logic [3:0]  m_a  [3];
    logic [15:0] m_d  [3];
    int unsigned m_st [3];
    int unsigned m_seq;
    int          m_rr;

    bit          rq_v [3];
    logic [3:0]  rq_a [3];
    logic [15:0] rq_d [3];
    int          acc  [3];

    logic [15:0] rf_dut [16];
    logic [15:0] rf_exp [16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive_idle();
        bus.alu_valid = 1'b0; bus.alu_addr = '0; bus.alu_value = '0;
        bus.mem_valid = 1'b0; bus.mem_addr = '0; bus.mem_value = '0;
        bus.ra_valid  = 1'b0; bus.ra_addr  = '0; bus.ra_value  = '0;
        bus.lookup_addr1 = '0;
        bus.lookup_addr2 = '0;
    endtask

    task automatic model_reset();
        for (int r = 0; r < 3; r++) begin
            m_v[r]  = 1'b0;
            rq_v[r] = 1'b0;
            acc[r]  = 0;
        end
        m_seq = 0;
        m_rr  = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        drive_idle();
        repeat (2) @(posedge clk);
        #1;
        check("rst_wb_writable", 32'(bus.wb_writable), 32'(0));
        check("rst_wb_addr", 32'(bus.wb_addr), 32'(0));
        check("rst_wb_value", 32'(bus.wb_value), 32'(0));
        check("rst_pend_hit", 32'({bus.pend_hit2, bus.pend_hit1}), 32'(0));
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rst_ready", 32'({bus.ra_ready, bus.mem_ready, bus.alu_ready}), 32'(3'b111));
        model_reset();
    endtask

    function automatic bit model_eligible(input int i);
        for (int j = 0; j < 3; j++) begin
            if (j != i && m_v[j] && m_a[j] == m_a[i] && m_st[j] < m_st[i]) return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic int model_grant();
        int idx;
        for (int k = 0; k < 3; k++) begin
            idx = (m_rr + k) % 3;
            if (m_v[idx] && model_eligible(idx)) return idx;
        end
        return -1;
    endfunction

    task automatic model_lookup(input logic [3:0] a, output logic hit, output logic [15:0] val);
        int unsigned best;
        hit  = 1'b0;
        val  = '0;
        best = 0;
        for (int r = 0; r < 3; r++) begin
            if (m_v[r] && m_a[r] == a && a != 4'd0 && (!hit || m_st[r] > best)) begin
                hit  = 1'b1;
                best = m_st[r];
                val  = m_d[r];
            end
        end
    endtask

    // One clock of modelled traffic; amax == 0 selects fixed addresses r+1 per requester.
    task automatic model_cycle(input int p_alu, input int p_mem, input int p_ra, input int amax);
        int          p [3];
        int          g;
        logic [2:0]  rdy_exp;
        logic [2:0]  rdy_dut;
        logic [3:0]  lk [2];
        logic        hit_e [2];
        logic [15:0] pv_e  [2];
        p = '{p_alu, p_mem, p_ra};
        @(negedge clk);
        for (int r = 0; r < 3; r++) begin
            if (!rq_v[r] && $urandom_range(0, 99) < p[r]) begin
                rq_v[r] = 1'b1;
                rq_a[r] = (amax == 0) ? 4'(r + 1) : 4'($urandom_range(0, amax));
                rq_d[r] = 16'($urandom);
            end
        end
        lk[0] = 4'($urandom_range(0, (amax == 0) ? 3 : amax));
        lk[1] = 4'($urandom_range(0, (amax == 0) ? 3 : amax));
        bus.alu_valid = rq_v[0]; bus.alu_addr = rq_a[0]; bus.alu_value = rq_d[0];
        bus.mem_valid = rq_v[1]; bus.mem_addr = rq_a[1]; bus.mem_value = rq_d[1];
        bus.ra_valid  = rq_v[2]; bus.ra_addr  = rq_a[2]; bus.ra_value  = rq_d[2];
        bus.lookup_addr1 = lk[0];
        bus.lookup_addr2 = lk[1];
        #2;
        g = model_grant();
        check("rnd_wb_writable", 32'(bus.wb_writable), 32'(g >= 0));
        if (g >= 0) begin
            check("rnd_wb_addr", 32'(bus.wb_addr), 32'(m_a[g]));
            check("rnd_wb_value", 32'(bus.wb_value), 32'(m_d[g]));
        end else begin
            check("rnd_wb_addr_idle", 32'(bus.wb_addr), 32'(0));
            check("rnd_wb_value_idle", 32'(bus.wb_value), 32'(0));
        end
        for (int r = 0; r < 3; r++) rdy_exp[r] = !m_v[r] || (g == r);
        rdy_dut = {bus.ra_ready, bus.mem_ready, bus.alu_ready};
        check("rnd_ready", 32'(rdy_dut), 32'(rdy_exp));
        model_lookup(lk[0], hit_e[0], pv_e[0]);
        model_lookup(lk[1], hit_e[1], pv_e[1]);
        check("rnd_pend_hit1", 32'(bus.pend_hit1), 32'(hit_e[0]));
        check("rnd_pend_value1", 32'(bus.pend_value1), 32'(pv_e[0]));
        check("rnd_pend_hit2", 32'(bus.pend_hit2), 32'(hit_e[1]));
        check("rnd_pend_value2", 32'(bus.pend_value2), 32'(pv_e[1]));
        if (bus.wb_writable) rf_dut[bus.wb_addr] = bus.wb_value;
        if (g >= 0) begin
            m_v[g] = 1'b0;
            m_rr   = (g + 1) % 3;
        end
        for (int r = 0; r < 3; r++) begin
            if (rq_v[r] && rdy_dut[r]) acc[r]++;
            if (rq_v[r] && rdy_exp[r]) begin
                if (rq_a[r] != 4'd0) begin
                    m_v[r]  = 1'b1;
                    m_a[r]  = rq_a[r];
                    m_d[r]  = rq_d[r];
                    m_st[r] = m_seq;
                    m_seq++;
                    rf_exp[rq_a[r]] = rq_d[r];
                end
                rq_v[r] = 1'b0;
            end
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b0;
        drive_idle();
        model_reset();

        //            v       a0    a1    a2    d0        d1        d2        lk1   lk2   wr    eaddr eval      erdy     h1    h2    pv1       pv2
        tbl[0]  = '{3'b111, 4'd1, 4'd2, 4'd4, 16'h0101, 16'h0202, 16'h0404, 4'd1, 4'd4, 1'b0, 4'd0, 16'h0000, 3'b111, 1'b0, 1'b0, 16'h0000, 16'h0000};
        tbl[1]  = '{3'b000, 4'd0, 4'd0, 4'd0, 16'h0000, 16'h0000, 16'h0000, 4'd1, 4'd4, 1'b1, 4'd1, 16'h0101, 3'b001, 1'b1, 1'b1, 16'h0101, 16'h0404};
        tbl[2]  = '{3'b000, 4'd0, 4'd0, 4'd0, 16'h0000, 16'h0000, 16'h0000, 4'd1, 4'd4, 1'b1, 4'd2, 16'h0202, 3'b011, 1'b0, 1'b1, 16'h0000, 16'h0404};
        tbl[3]  = '{3'b000, 4'd0, 4'd0, 4'd0, 16'h0000, 16'h0000, 16'h0000, 4'd1, 4'd4, 1'b1, 4'd4, 16'h0404, 3'b111, 1'b0, 1'b1, 16'h0000, 16'h0404};
        tbl[4]  = '{3'b011, 4'd9, 4'd5, 4'd0, 16'h0999, 16'hAAAA, 16'h0000, 4'd5, 4'd9, 1'b0, 4'd0, 16'h0000, 3'b111, 1'b0, 1'b0, 16'h0000, 16'h0000};
        tbl[5]  = '{3'b001, 4'd5, 4'd0, 4'd0, 16'hBBBB, 16'h0000, 16'h0000, 4'd5, 4'd9, 1'b1, 4'd9, 16'h0999, 3'b101, 1'b1, 1'b1, 16'hAAAA, 16'h0999};
        tbl[6]  = '{3'b000, 4'd0, 4'd0, 4'd0, 16'h0000, 16'h0000, 16'h0000, 4'd5, 4'd9, 1'b1, 4'd5, 16'hAAAA, 3'b110, 1'b1, 1'b0, 16'hBBBB, 16'h0000};
        tbl[7]  = '{3'b000, 4'd0, 4'd0, 4'd0, 16'h0000, 16'h0000, 16'h0000, 4'd5, 4'd9, 1'b1, 4'd5, 16'hBBBB, 3'b111, 1'b1, 1'b0, 16'hBBBB, 16'h0000};
        tbl[8]  = '{3'b000, 4'd0, 4'd0, 4'd0, 16'h0000, 16'h0000, 16'h0000, 4'd5, 4'd9, 1'b0, 4'd0, 16'h0000, 3'b111, 1'b0, 1'b0, 16'h0000, 16'h0000};
        tbl[9]  = '{3'b001, 4'd3, 4'd0, 4'd0, 16'h1234, 16'h0000, 16'h0000, 4'd3, 4'd0, 1'b0, 4'd0, 16'h0000, 3'b111, 1'b0, 1'b0, 16'h0000, 16'h0000};
        tbl[10] = '{3'b000, 4'd0, 4'd0, 4'd0, 16'h0000, 16'h0000, 16'h0000, 4'd3, 4'd0, 1'b1, 4'd3, 16'h1234, 3'b111, 1'b1, 1'b0, 16'h1234, 16'h0000};
        tbl[11] = '{3'b000, 4'd0, 4'd0, 4'd0, 16'h0000, 16'h0000, 16'h0000, 4'd3, 4'd0, 1'b0, 4'd0, 16'h0000, 3'b111, 1'b0, 1'b0, 16'h0000, 16'h0000};
        tbl[12] = '{3'b001, 4'd0, 4'd0, 4'd0, 16'hDEAD, 16'h0000, 16'h0000, 4'd0, 4'd0, 1'b0, 4'd0, 16'h0000, 3'b111, 1'b0, 1'b0, 16'h0000, 16'h0000};
        tbl[13] = '{3'b000, 4'd0, 4'd0, 4'd0, 16'h0000, 16'h0000, 16'h0000, 4'd0, 4'd0, 1'b0, 4'd0, 16'h0000, 3'b111, 1'b0, 1'b0, 16'h0000, 16'h0000};
        tbl[14] = '{3'b000, 4'd0, 4'd0, 4'd0, 16'h0000, 16'h0000, 16'h0000, 4'd0, 4'd0, 1'b0, 4'd0, 16'h0000, 3'b111, 1'b0, 1'b0, 16'h0000, 16'h0000};

        do_reset();

        // Directed vectors: one row per cycle, outputs reflect state left by earlier rows.
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            bus.alu_valid = tbl[i].v[0]; bus.alu_addr = tbl[i].a0; bus.alu_value = tbl[i].d0;
            bus.mem_valid = tbl[i].v[1]; bus.mem_addr = tbl[i].a1; bus.mem_value = tbl[i].d1;
            bus.ra_valid  = tbl[i].v[2]; bus.ra_addr  = tbl[i].a2; bus.ra_value  = tbl[i].d2;
            bus.lookup_addr1 = tbl[i].lk1;
            bus.lookup_addr2 = tbl[i].lk2;
            #2;
            check($sformatf("vec%0d_wb_writable", i), 32'(bus.wb_writable), 32'(tbl[i].ewr));
            check($sformatf("vec%0d_wb_addr", i), 32'(bus.wb_addr), 32'(tbl[i].eaddr));
            check($sformatf("vec%0d_wb_value", i), 32'(bus.wb_value), 32'(tbl[i].eval));
            check($sformatf("vec%0d_ready", i), 32'({bus.ra_ready, bus.mem_ready, bus.alu_ready}), 32'(tbl[i].erdy));
            check($sformatf("vec%0d_pend_hit1", i), 32'(bus.pend_hit1), 32'(tbl[i].ehit1));
            check($sformatf("vec%0d_pend_hit2", i), 32'(bus.pend_hit2), 32'(tbl[i].ehit2));
            check($sformatf("vec%0d_pend_value1", i), 32'(bus.pend_value1), 32'(tbl[i].epv1));
            check($sformatf("vec%0d_pend_value2", i), 32'(bus.pend_value2), 32'(tbl[i].epv2));
        end

        // ALU and MEM hold valid every cycle: writes alternate, accepts land on alternate edges.
        do_reset();
        for (int c = 0; c < 6; c++) model_cycle(100, 100, 0, 0);
        check("alt_alu_accepts", 32'(acc[0]), 32'(4));
        check("alt_mem_accepts", 32'(acc[1]), 32'(3));
        for (int c = 0; c < 4; c++) model_cycle(0, 0, 0, 0);

        // Reset asserted mid-cycle with all three buffers full.
        do_reset();
        @(negedge clk);
        bus.alu_valid = 1'b1; bus.alu_addr = 4'd1; bus.alu_value = 16'h1111;
        bus.mem_valid = 1'b1; bus.mem_addr = 4'd2; bus.mem_value = 16'h2222;
        bus.ra_valid  = 1'b1; bus.ra_addr  = 4'd3; bus.ra_value  = 16'h3333;
        @(negedge clk);
        drive_idle();
        bus.lookup_addr1 = 4'd2;
        bus.lookup_addr2 = 4'd3;
        #2;
        check("mid_rst_pre_writable", 32'(bus.wb_writable), 32'(1));
        check("mid_rst_pre_addr", 32'(bus.wb_addr), 32'(1));
        check("mid_rst_pre_hit", 32'({bus.pend_hit2, bus.pend_hit1}), 32'(2'b11));
        #1;
        rst = 1'b0;
        #1;
        check("mid_rst_writable", 32'(bus.wb_writable), 32'(0));
        check("mid_rst_wb_value", 32'(bus.wb_value), 32'(0));
        check("mid_rst_hit", 32'({bus.pend_hit2, bus.pend_hit1}), 32'(0));
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            #2;
            check("post_rst_writable", 32'(bus.wb_writable), 32'(0));
            check("post_rst_hit", 32'({bus.pend_hit2, bus.pend_hit1}), 32'(0));
        end
        model_reset();

        // Randomized traffic with heavy address collisions, including the zero register.
        for (int a = 0; a < 16; a++) begin
            rf_dut[a] = '0;
            rf_exp[a] = '0;
        end
        for (int c = 0; c < 400; c++) model_cycle(60, 60, 60, 3);
        for (int c = 0; c < 8; c++) model_cycle(0, 0, 0, 3);
        for (int a = 0; a < 16; a++) begin
            check($sformatf("final_rf%0d", a), 32'(rf_dut[a]), 32'(rf_exp[a]));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/reg_wb_arbiter.md
Name: reg_wb_arbiter

Overview:
- Shares the register file's single write port (writable / write_addr / write_value) between three writeback requesters: ALU result, memory load result and RA link.
- Each requester gets a 1-entry holding buffer with valid/ready handshake; a round-robin arbiter drains one buffer per cycle.
- Same-register writes always drain oldest-first.
- Exposes pending-write lookup, with youngest-value forwarding, so decode can bypass or stall.

Parameters:
- DATA_W, 16, register value width
- ADDR_W, 4, register address width
- ZERO_REG, 0, hardwired-zero register address; writes to it are discarded

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- alu_valid  in  1  ALU writeback request
- alu_addr  in  ADDR_W  ALU destination
- alu_value  in  DATA_W  ALU result
- alu_ready  out  1  ALU buffer can accept
- mem_valid / mem_addr / mem_value / mem_ready  as ALU, memory-load requester
- ra_valid / ra_addr / ra_value / ra_ready  as ALU, link requester
- wb_writable  out  1  register-file write enable
- wb_addr  out  ADDR_W  register-file write address
- wb_value  out  DATA_W  register-file write data
- lookup_addr1, lookup_addr2  in  ADDR_W  decode read addresses
- pend_hit1, pend_hit2  out  1  lookup address has a buffered, unwritten value
- pend_value1, pend_value2  out  DATA_W  youngest buffered value for that address

Behaviour:
- Reset (rst low, asynchronous):
  - all buffers empty; age matrix cleared; rr_ptr = 0 (ALU)
  - all outputs are combinational from state, giving: wb_writable = 0, wb_addr = 0, wb_value = 0, pend_hit* = 0, pend_value* = 0
  - all ready = 1 once rst is high
- Reset mid-operation discards buffered writes; no partial write is issued.
- Handshake:
  - transfer on rising clk when valid & ready
  - ready = buffer empty OR buffer granted this cycle, so back-to-back transfers run at 1 per cycle per requester
  - ready never depends on own valid
- Zero register: a transfer with addr == ZERO_REG completes (ready honoured) but loads nothing.
- Latency: handshake at edge N, buffer occupied during cycle N+1; if granted, wb_* are driven combinationally in N+1 and the buffer frees at edge N+2. Minimum 1 cycle, no combinational valid-to-wb path.
- Age tracking:
  - 3x3 older[i][j] matrix, updated on load: a new entry is younger than every occupied entry
  - same-edge loads are ordered ALU older than MEM older than RA
- Eligibility: an occupied buffer is eligible unless another occupied buffer holds the same addr and is older.
- Grant:
  - among eligible buffers, first at or after rr_ptr in order ALU, MEM, RA
  - after a grant, rr_ptr = granted index + 1 mod 3; rr_ptr unchanged when idle
  - exactly one grant when any buffer is occupied; wb_writable = 0 otherwise, with wb_addr and wb_value held at 0
- Forwarding lookup (combinational):
  - pend_hit = any occupied buffer with matching addr and addr != ZERO_REG
  - pend_value = value of the youngest such buffer
  - a buffer granted this cycle still counts as pending
- Simultaneous load and grant of the same requester: the grant frees the old entry and the new entry loads, youngest.
- Starvation bound: round-robin plus oldest-first guarantees every entry drains within 3 grant cycles.

Decomposition:
- Shared package (define header): requester index constants REQ_ALU=0, REQ_MEM=1, REQ_RA=2, NUM_REQ=3, the Writeable encoding, and the ZeroReg address.
- One natural sub-module: wb_slot (1-entry buffer: valid/addr/value, load/clear, ready logic), instantiated three times.
- Age matrix, eligibility, round-robin grant and lookup muxes stay in the top module.

Test Plan:
- Reset then single ALU write addr=3 value=0x1234 -> next cycle wb_writable=1, wb_addr=3, wb_value=0x1234; following cycle wb_writable=0; alu_ready stays 1.
- ALU, MEM and RA all valid same edge to addrs 1, 2, 4 -> grants ALU, MEM, RA on three consecutive cycles; rr_ptr returns to 0.
- MEM addr=5 value=0xAAAA loaded, ALU addr=5 value=0xBBBB one cycle later while MEM blocked -> MEM writes first, then ALU; pend_value for addr 5 shows 0xBBBB while both are pending.
- ALU request to addr=0 -> alu_ready=1, transfer completes, wb_writable never asserts, pend_hit1 with lookup_addr1=0 stays 0.
- ALU valid every cycle for 6 cycles with MEM also valid every cycle -> writes alternate ALU/MEM; each requester sees ready=1 on every alternate edge and no request is lost.
- Three buffers loaded, rst pulsed low mid-cycle -> wb_writable and pend_hit* fall immediately; after release, no stale write appears.
